analyzer_trigger_unit: RTL and testbench

//  Trigger generator upstream of the 16x64x64 logic analyzer. Compares a probe bus against

---
 rtl/analyzer_trig_pkg.sv | 20 ++
 rtl/analyzer_trig_match.sv | 45 ++++
 rtl/analyzer_trigger_unit.sv | 159 +++++++++++++++
 tb/tb_analyzer_trigger_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/analyzer_trig_pkg.sv
// Shared types for the analyzer trigger unit: FSM states, trigger mode codes, default widths.
package analyzer_trig_pkg;

  localparam int unsigned DefaultCntW = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StDelay = 2'd2,
    StFired = 2'd3
  } trig_state_e;

  typedef enum logic [1:0] {
    TRIG_LEVEL = 2'd0,
    TRIG_RISE  = 2'd1,
    TRIG_FALL  = 2'd2,
    TRIG_FORCE = 2'd3
  } trig_mode_e;

endpackage

// File: rtl/analyzer_trig_match.sv
// Masked probe compare plus one cycle of match history, reduced to a per-cycle event by mode.
module analyzer_trig_match
  import analyzer_trig_pkg::*;
#(
  parameter int unsigned PROBE_W = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [PROBE_W-1:0] probe_i,
  input  logic [PROBE_W-1:0] mask_i,
  input  logic [PROBE_W-1:0] value_i,
  input  logic [1:0]         mode_i,
  input  logic               clr_i,
  output logic               evt_o
);

  logic match;
  logic match_q, match_d;

  always_comb begin
    match   = ((probe_i ^ value_i) & mask_i) == '0;
    // Cleared on arm so a probe already matching counts as an entering edge.
    match_d = clr_i ? 1'b0 : match;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  always_comb begin
    evt_o = 1'b0;
    unique case (trig_mode_e'(mode_i))
      TRIG_LEVEL: evt_o = match;
      TRIG_RISE:  evt_o = match & ~match_q;
      TRIG_FALL:  evt_o = ~match & match_q;
      TRIG_FORCE: evt_o = 1'b1;
      default:    evt_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/analyzer_trigger_unit.sv
// Trigger generator for the logic analyzer: event counting, post-match delay, hold until full.
// Optional auto-fire timeout enabled by defining ANALYZER_TRIG_TIMEOUT_EN.
module analyzer_trigger_unit
  import analyzer_trig_pkg::*;
#(
  parameter int unsigned PROBE_W = 64,
  parameter int unsigned CNT_W   = DefaultCntW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PROBE_W-1:0] probe,
  input  logic [PROBE_W-1:0] cfg_mask,
  input  logic [PROBE_W-1:0] cfg_value,
  input  logic [1:0]         cfg_mode,
  input  logic [CNT_W-1:0]   cfg_count,
  input  logic [CNT_W-1:0]   cfg_delay,
  input  logic [CNT_W-1:0]   cfg_timeout,
  input  logic               arm,
  input  logic               abort,
  input  logic               cap_full,
  output logic               trigger,
  output logic               armed,
  output logic               done,
  output logic               timed_out,
  output logic [CNT_W-1:0]   event_cnt
);

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W:0]   CntOneX = (CNT_W+1)'(1);

  trig_state_e      state_q, state_d;
  logic [CNT_W-1:0] event_cnt_q, event_cnt_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic             done_q, done_d;
  logic             evt, arm_accept, fire_timeout, timeout_hit, count_hit;
  logic [CNT_W-1:0] cnt_sat;
  logic [CNT_W:0]   cnt_plus1, cnt_need;

  analyzer_trig_match #(
    .PROBE_W(PROBE_W)
  ) u_match (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .probe_i(probe),
    .mask_i (cfg_mask),
    .value_i(cfg_value),
    .mode_i (cfg_mode),
    .clr_i  (arm_accept),
    .evt_o  (evt)
  );

  always_comb begin
    cnt_sat   = (event_cnt_q == '1) ? event_cnt_q : event_cnt_q + CntOne;
    // Compare one bit wider so the +1 cannot wrap; a zero count behaves as one.
    cnt_plus1 = {1'b0, event_cnt_q} + CntOneX;
    cnt_need  = (cfg_count == '0) ? CntOneX : {1'b0, cfg_count};
    count_hit = evt && (cnt_plus1 >= cnt_need);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      event_cnt_q <= '0;
      dly_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      event_cnt_q <= event_cnt_d;
      dly_q       <= dly_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    event_cnt_d  = event_cnt_q;
    dly_d        = dly_q;
    arm_accept   = 1'b0;
    fire_timeout = 1'b0;
    done_d       = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm && !cap_full) begin
            state_d     = StArmed;
            event_cnt_d = '0;
            arm_accept  = 1'b1;
          end
        end
        StArmed: begin
          if (evt) event_cnt_d = cnt_sat;
          if (count_hit) begin
            state_d = StDelay;
            dly_d   = cfg_delay;
          end else if (timeout_hit) begin
            state_d      = StFired;
            fire_timeout = 1'b1;
          end
        end
        StDelay: begin
          if (dly_q == '0) state_d = StFired;
          else dly_d = dly_q - CntOne;
        end
        StFired: begin
          if (cap_full) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    trigger   = (state_q == StFired);
    armed     = (state_q == StArmed) || (state_q == StDelay);
    done      = done_q;
    event_cnt = event_cnt_q;
  end

`ifdef ANALYZER_TRIG_TIMEOUT_EN
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             timed_out_q, timed_out_d;

  always_comb begin
    timer_d     = timer_q;
    timed_out_d = timed_out_q;
    if (arm_accept) begin
      timer_d     = '0;
      timed_out_d = 1'b0;
    end else begin
      if (state_q == StArmed && timer_q != '1) timer_d = timer_q + CntOne;
      if (fire_timeout) timed_out_d = 1'b1;
    end
    // Fires on the cycle the timer would step onto cfg_timeout.
    timeout_hit = (cfg_timeout != '0) && (({1'b0, timer_q} + CntOneX) >= {1'b0, cfg_timeout});
    timed_out   = timed_out_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q     <= '0;
      timed_out_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      timed_out_q <= timed_out_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^{cfg_timeout, fire_timeout};
  assign timeout_hit    = 1'b0;
  assign timed_out      = 1'b0;
`endif

endmodule

// File: tb/tb_analyzer_trigger_unit.sv
// Self-checking bench for analyzer_trigger_unit: vector table, corner sequences, random traces.
module tb_analyzer_trigger_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] probe = '0, cfg_mask = '0, cfg_value = '0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [15:0] cfg_count = 16'd1, cfg_delay = '0, cfg_timeout = '0;
  logic        arm = 1'b0, abort = 1'b0, cap_full = 1'b0;
  logic        trigger, armed, done, timed_out;
  logic [15:0] event_cnt;

  int checks = 0;
  int failures = 0;

  analyzer_trigger_unit #(
    .PROBE_W(64),
    .CNT_W  (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .probe      (probe),
    .cfg_mask   (cfg_mask),
    .cfg_value  (cfg_value),
    .cfg_mode   (cfg_mode),
    .cfg_count  (cfg_count),
    .cfg_delay  (cfg_delay),
    .cfg_timeout(cfg_timeout),
    .arm        (arm),
    .abort      (abort),
    .cap_full   (cap_full),
    .trigger    (trigger),
    .armed      (armed),
    .done       (done),
    .timed_out  (timed_out),
    .event_cnt  (event_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] mask;
    logic [63:0] value;
    logic [63:0] pr;
    logic [15:0] count;
    logic [15:0] delay;
    int          lat;      // first trigger cycle after arm, -1 = never
    int          exp_cnt;
  } vec_t;

  vec_t        vecs[11];
  localparam int W = 40;
  logic [63:0] tr[W];
  int          cntexp[W];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic go_idle();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [63:0] mk, input logic [63:0] v,
                         input logic [15:0] c, input logic [15:0] d);
    cfg_mode = m; cfg_mask = mk; cfg_value = v; cfg_count = c; cfg_delay = d;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{2'd0, 64'hFF, 64'h5A, 64'h5A, 16'd1, 16'd0, 2, 1};
    vecs[1]  = '{2'd0, 64'hFF, 64'h5A, 64'h5A, 16'd3, 16'd2, 6, 3};
    vecs[2]  = '{2'd0, 64'hFF, 64'h5A, 64'h5A, 16'd0, 16'd1, 3, 1};
    vecs[3]  = '{2'd0, 64'hFF, 64'h5A, 64'hA5, 16'd1, 16'd0, -1, 0};
    vecs[4]  = '{2'd1, 64'hFF, 64'h5A, 64'h5A, 16'd1, 16'd0, 2, 1};
    vecs[5]  = '{2'd1, 64'hFF, 64'h5A, 64'h5A, 16'd2, 16'd0, -1, 1};
    vecs[6]  = '{2'd2, 64'hFF, 64'h5A, 64'h5A, 16'd1, 16'd0, -1, 0};
    vecs[7]  = '{2'd3, 64'hFF, 64'h5A, 64'hA5, 16'd4, 16'd3, 8, 4};
    vecs[8]  = '{2'd0, 64'h0, 64'h5A, 64'h1234, 16'd2, 16'd0, 3, 2};
    vecs[9]  = '{2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, '1, 16'd1, 16'd5, 7, 1};
    vecs[10] = '{2'd2, 64'hFF, 64'h5A, 64'hA5, 16'd1, 16'd0, -1, 0};

    // Reset state
    tick(); tick();
    chk("rst trigger", trigger, 0);
    chk("rst armed", armed, 0);
    chk("rst done", done, 0);
    chk("rst timed_out", timed_out, 0);
    chk("rst event_cnt", event_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Vector table: constant probe after arm
    for (int i = 0; i < 11; i++) begin
      set_cfg(vecs[i].mode, vecs[i].mask, vecs[i].value, vecs[i].count, vecs[i].delay);
      probe = vecs[i].pr;
      do_arm();
      for (int t = 0; t < 30; t++) begin
        chk($sformatf("vec%0d trig t%0d", i, t), trigger,
            (vecs[i].lat >= 0 && t >= vecs[i].lat) ? 1 : 0);
        tick();
      end
      chk($sformatf("vec%0d event_cnt", i), event_cnt, vecs[i].exp_cnt);
      go_idle();
      chk($sformatf("vec%0d idle", i), armed | trigger, 0);
    end

    // Match at cycle 10 -> trigger at 12
    set_cfg(2'd0, 64'hFF, 64'h5A, 16'd1, 16'd0);
    probe = '0;
    do_arm();
    for (int t = 0; t < 14; t++) begin
      chk($sformatf("lat trig t%0d", t), trigger, (t >= 12) ? 1 : 0);
      chk($sformatf("lat armed t%0d", t), armed, (t < 12) ? 1 : 0);
      probe = (t == 10) ? 64'h5A : 64'h0;
      tick();
    end
    go_idle();

    // RISE, count 3, delay 2, match on odd cycles
    set_cfg(2'd1, 64'hFF, 64'h5A, 16'd3, 16'd2);
    probe = '0;
    do_arm();
    for (int t = 0; t < 11; t++) begin
      chk($sformatf("rise cnt t%0d", t), event_cnt, (t / 2 > 3) ? 3 : t / 2);
      chk($sformatf("rise trig t%0d", t), trigger, (t >= 9) ? 1 : 0);
      chk($sformatf("rise armed t%0d", t), armed, (t < 9) ? 1 : 0);
      probe = (t % 2 == 1 && t <= 9) ? 64'h5A : 64'h0;
      tick();
    end
    go_idle();

    // delay 4 -> trigger at 16, cap_full 7 cycles later, done pulse
    set_cfg(2'd0, 64'hFF, 64'h5A, 16'd1, 16'd4);
    probe = '0;
    do_arm();
    for (int t = 0; t < 26; t++) begin
      chk($sformatf("dly trig t%0d", t), trigger, (t >= 16 && t < 24) ? 1 : 0);
      chk($sformatf("dly done t%0d", t), done, (t == 24) ? 1 : 0);
      chk($sformatf("dly armed t%0d", t), armed, (t < 16) ? 1 : 0);
      probe = (t == 10) ? 64'h5A : 64'h0;
      cap_full = (t == 23);
      tick();
    end
    chk("dly event_cnt held", event_cnt, 1);

    // Abort during DELAY
    set_cfg(2'd0, 64'hFF, 64'h5A, 16'd1, 16'd5);
    probe = 64'h5A;
    do_arm();
    for (int t = 0; t < 16; t++) begin
      chk($sformatf("abort trig t%0d", t), trigger, 0);
      chk($sformatf("abort done t%0d", t), done, 0);
      chk($sformatf("abort armed t%0d", t), armed, (t < 4) ? 1 : 0);
      abort = (t == 3);
      tick();
    end
    abort = 1'b0;

    // arm and abort together
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    for (int t = 0; t < 8; t++) begin
      chk($sformatf("armabort t%0d", t), {armed, trigger, done}, 0);
      tick();
    end

    // Reset while FIRED, then arm with cap_full high
    set_cfg(2'd0, 64'hFF, 64'h5A, 16'd1, 16'd0);
    probe = 64'h5A;
    do_arm();
    tick(); tick();
    chk("pre-reset fired", trigger, 1);
    rst_n = 1'b0;
    tick();
    chk("midrst trigger", trigger, 0);
    chk("midrst armed", armed, 0);
    chk("midrst done", done, 0);
    chk("midrst timed_out", timed_out, 0);
    chk("midrst event_cnt", event_cnt, 0);
    rst_n = 1'b1;
    cap_full = 1'b1;
    do_arm();
    for (int t = 0; t < 5; t++) begin
      chk($sformatf("capfull arm t%0d", t), {armed, trigger}, 0);
      tick();
    end
    cap_full = 1'b0;

`ifdef ANALYZER_TRIG_TIMEOUT_EN
    // Timeout 20, no match: trigger 21 cycles after the arm cycle
    set_cfg(2'd0, 64'hFF, 64'h5A, 16'd1, 16'd0);
    cfg_timeout = 16'd20;
    probe = '0;
    do_arm();
    for (int t = 0; t < 22; t++) begin
      chk($sformatf("to trig t%0d", t), trigger, (t >= 20) ? 1 : 0);
      chk($sformatf("to flag t%0d", t), timed_out, (t >= 20) ? 1 : 0);
      tick();
    end
    go_idle();
    chk("to sticky", timed_out, 1);
    // Count reached on the timeout cycle: the real event wins
    set_cfg(2'd0, 64'hFF, 64'h5A, 16'd20, 16'd0);
    probe = 64'h5A;
    do_arm();
    chk("to cleared by arm", timed_out, 0);
    for (int t = 0; t < 23; t++) begin
      chk($sformatf("tie trig t%0d", t), trigger, (t >= 21) ? 1 : 0);
      chk($sformatf("tie flag t%0d", t), timed_out, 0);
      tick();
    end
    go_idle();
    // timeout 0 never fires
    set_cfg(2'd0, 64'hFF, 64'h5A, 16'd1, 16'd0);
    cfg_timeout = 16'd0;
    probe = '0;
    do_arm();
    for (int t = 0; t < 40; t++) begin
      chk($sformatf("to0 trig t%0d", t), trigger, 0);
      tick();
    end
    go_idle();
`endif

    // Random traces against a trace-level model
    for (int it = 0; it < 40; it++) begin
      logic [1:0]  m;
      logic [63:0] mk, v;
      logic [15:0] c, d;
      int need, seen, fire;
      bit prev, cur, ev, fired;
      m  = 2'($urandom_range(0, 3));
      mk = {60'h0, 4'($urandom)};
      v  = {$urandom, $urandom};
      c  = 16'($urandom_range(0, 4));
      d  = 16'($urandom_range(0, 3));
      need = (c == 0) ? 1 : int'(c);
      seen = 0; fire = -1; prev = 1'b0;
      for (int t = 0; t < W; t++) begin
        tr[t] = {v[63:4], 4'($urandom)};
        cur = 1'b1;
        for (int b = 0; b < 64; b++) if (mk[b] && tr[t][b] != v[b]) cur = 1'b0;
        case (m)
          2'd0: ev = cur;
          2'd1: ev = cur && !prev;
          2'd2: ev = !cur && prev;
          default: ev = 1'b1;
        endcase
        cntexp[t] = (seen < need) ? seen : need;
        if (ev) seen++;
        if (fire < 0 && seen >= need) fire = t + 2 + int'(d);
        prev = cur;
      end
      set_cfg(m, mk, v, c, d);
      do_arm();
      for (int t = 0; t < W; t++) begin
        fired = (fire >= 0 && t >= fire);
        chk($sformatf("rnd%0d trig t%0d", it, t), trigger, fired);
        chk($sformatf("rnd%0d armed t%0d", it, t), armed, !fired);
        chk($sformatf("rnd%0d cnt t%0d", it, t), event_cnt, cntexp[t]);
        chk($sformatf("rnd%0d to t%0d", it, t), timed_out, 0);
        probe = tr[t];
        tick();
      end
      fired = (fire >= 0 && fire <= W);
      chk($sformatf("rnd%0d trig end", it), trigger, fired);
      if (fired) begin
        cap_full = 1'b1;
        tick();
        cap_full = 1'b0;
        chk($sformatf("rnd%0d done", it), {done, trigger, armed}, 3'b100);
        tick();
        chk($sformatf("rnd%0d done off", it), done, 0);
      end else begin
        go_idle();
        chk($sformatf("rnd%0d aborted", it), {done, trigger, armed}, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
